// File: rtl/mfp_ahb_interconnect_if.sv
// rtl/mfp_ahb_interconnect_if.sv - AHB-Lite master-side and slave-side bus bundle for the interconnect
//
// Purpose : groups the single master's address/response signals together with the
//           per-slave select/ready/response/read-data vectors.
// Signals : HADDR, HTRANS, HWRITE      master address phase
//           HRDATA, HREADY, HRESP      response to master (HREADY also broadcast to slaves)
//           HSEL_S                     one-hot slave select, address phase
//           HREADYOUT_S, HRESP_S       per-slave ready / response
//           HRDATA_S                   per-slave read data, slave i at [32*i+:32]
// Modports: slave  - the interconnect's view
//           master - the view of the environment (core plus slaves)

interface mfp_ahb_interconnect_if #(
    parameter int N_SLAVES = 4
) ();

    logic [31:0]             HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [31:0]             HRDATA;
    logic                    HREADY;
    logic                    HRESP;
    logic [N_SLAVES-1:0]     HSEL_S;
    logic [N_SLAVES-1:0]     HREADYOUT_S;
    logic [N_SLAVES-1:0]     HRESP_S;
    logic [32*N_SLAVES-1:0]  HRDATA_S;

    modport slave (
        input  HADDR, HTRANS, HWRITE, HREADYOUT_S, HRESP_S, HRDATA_S,
        output HRDATA, HREADY, HRESP, HSEL_S
    );

    modport master (
        output HADDR, HTRANS, HWRITE, HREADYOUT_S, HRESP_S, HRDATA_S,
        input  HRDATA, HREADY, HRESP, HSEL_S
    );

endinterface

// File: rtl/mfp_ahb_interconnect.sv
// rtl/mfp_ahb_interconnect.sv - AHB-Lite single-master decoder/response mux with default error slave
//
// Purpose : decodes the master address onto N_SLAVES slaves (lowest index wins on overlap),
//           multiplexes the selected slave's data-phase response back to the master, and
//           answers unmapped active transfers with a two-cycle ERROR from a built-in default
//           slave. Default-slave errors are counted (saturating), the last failing
//           address/direction is logged, and a sticky interrupt is raised.
// Ports   : HCLK       bus clock
//           HRESETn    asynchronous active-low reset
//           bus        mfp_ahb_interconnect_if.slave (master + per-slave bus signals)
//           ERR_IRQ    sticky default-slave error flag
//           ERR_CLR    one-cycle pulse clearing ERR_IRQ (a same-cycle new error wins)
//           ERR_COUNT  saturating count of default-slave errors
//           ERR_ADDR   HADDR of the most recent unmapped active transfer
//           ERR_WRITE  HWRITE of that transfer

module mfp_ahb_interconnect #(
    parameter int                     N_SLAVES  = 4,
    parameter logic [32*N_SLAVES-1:0] SLV_BASE  = {32'h1F80_0000, 32'h1F40_0000,
                                                   32'h0000_0000, 32'h1FC0_0000},
    parameter logic [32*N_SLAVES-1:0] SLV_MASK  = {32'hFFFF_0000, 32'hFFFF_0000,
                                                   32'hFFFC_0000, 32'hFFFF_0000},
    parameter int                     ERR_CNT_W = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    mfp_ahb_interconnect_if.slave bus,
    output logic                 ERR_IRQ,
    input  logic                 ERR_CLR,
    output logic [ERR_CNT_W-1:0] ERR_COUNT,
    output logic [31:0]          ERR_ADDR,
    output logic                 ERR_WRITE
);

    // Data-phase owner of the response path
    localparam logic [1:0] ST_NONE = 2'd0;  // no transfer in data phase: OKAY, zero data
    localparam logic [1:0] ST_SLV  = 2'd1;  // a real slave owns the data phase
    localparam logic [1:0] ST_ERR1 = 2'd2;  // default slave, first ERROR cycle (stall)
    localparam logic [1:0] ST_ERR2 = 2'd3;  // default slave, second ERROR cycle

    logic [1:0]           st_q, st_d;
    logic [N_SLAVES-1:0]  dsel_q, dsel_d;
    logic                 err_irq_q, err_irq_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]          err_addr_q, err_addr_d;
    logic                 err_write_q, err_write_d;

    logic [N_SLAVES-1:0]  hit_sel;
    logic                 hit_any;
    logic                 active;
    logic                 log_err;

    logic [31:0]          slv_rdata;
    logic                 slv_ready;
    logic                 slv_resp;

    logic [31:0]          hrdata;
    logic                 hready;
    logic                 hresp;

    // ------------------------------------------------------------------
    // Address decode: first matching window in index order wins, so the
    // select is one-hot or zero even when windows overlap.
    // ------------------------------------------------------------------
    always_comb begin
        hit_sel = '0;
        hit_any = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!hit_any &&
                ((bus.HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hit_sel[i] = 1'b1;
                hit_any    = 1'b1;
            end
        end
    end

    // Slaves qualify the select with HTRANS themselves.
    assign bus.HSEL_S = hit_sel;

    assign active = bus.HTRANS[1];

    // ------------------------------------------------------------------
    // Data-phase response mux from the slave latched in dsel_q.
    // dsel_q is one-hot or zero, so an OR-reduction is a clean mux.
    // ------------------------------------------------------------------
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (dsel_q[i]) begin
                slv_rdata = slv_rdata | bus.HRDATA_S[32*i +: 32];
                slv_ready = slv_ready | bus.HREADYOUT_S[i];
                slv_resp  = slv_resp  | bus.HRESP_S[i];
            end
        end
    end

    // Outputs depend only on registered state plus slave inputs, so an
    // asynchronous reset drives them to idle values immediately.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        case (st_q)
            ST_SLV: begin
                hrdata = slv_rdata;
                hready = slv_ready;
                hresp  = slv_resp;
            end
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
            default: begin
                hrdata = '0;
                hready = 1'b1;
                hresp  = 1'b0;
            end
        endcase
    end

    assign bus.HRDATA = hrdata;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;

    // ------------------------------------------------------------------
    // Next state. A new address phase is only taken when HREADY=1; ERR1
    // drives HREADY low, so anything presented during ERR1 is ignored and
    // re-presented by the master in ERR2.
    // ------------------------------------------------------------------
    always_comb begin
        st_d    = st_q;
        dsel_d  = dsel_q;
        log_err = 1'b0;
        if (st_q == ST_ERR1) begin
            st_d   = ST_ERR2;
            dsel_d = '0;
        end else if (hready) begin
            if (!active) begin
                st_d   = ST_NONE;
                dsel_d = '0;
            end else if (hit_any) begin
                st_d   = ST_SLV;
                dsel_d = hit_sel;
            end else begin
                st_d    = ST_ERR1;
                dsel_d  = '0;
                log_err = 1'b1;
            end
        end
    end

    // Error log: captured on the edge that enters ERR1, which is the edge
    // that accepts the failing address phase.
    always_comb begin
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        err_cnt_d   = err_cnt_q;
        err_irq_d   = err_irq_q;
        if (ERR_CLR) begin
            err_irq_d = 1'b0;
        end
        if (log_err) begin
            err_addr_d  = bus.HADDR;
            err_write_d = bus.HWRITE;
            err_irq_d   = 1'b1;  // set beats a coincident clear
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st_q        <= ST_NONE;
            dsel_q      <= '0;
            err_irq_q   <= 1'b0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            dsel_q      <= dsel_d;
            err_irq_q   <= err_irq_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
        end
    end

    assign ERR_IRQ   = err_irq_q;
    assign ERR_COUNT = err_cnt_q;
    assign ERR_ADDR  = err_addr_q;
    assign ERR_WRITE = err_write_q;

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// tb/tb_mfp_ahb_interconnect.sv - directed self-checking bench for mfp_ahb_interconnect

module tb_mfp_ahb_interconnect;

    localparam int NS = 4;

    logic        HCLK;
    logic        HRESETn;
    logic        ERR_IRQ;
    logic        ERR_CLR;
    logic [15:0] ERR_COUNT;
    logic [31:0] ERR_ADDR;
    logic        ERR_WRITE;

    int n_cmp;
    int n_bad;

    mfp_ahb_interconnect_if #(.N_SLAVES(NS)) bus ();

    // Slave 3 window widened to 0x1F80_0000..0x1FFF_FFFF so it overlaps slave 0.
    mfp_ahb_interconnect #(
        .N_SLAVES (NS),
        .SLV_BASE ({32'h1F80_0000, 32'h1F40_0000, 32'h0000_0000, 32'h1FC0_0000}),
        .SLV_MASK ({32'hFF80_0000, 32'hFFFF_0000, 32'hFFFC_0000, 32'hFFFF_0000}),
        .ERR_CNT_W(16)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .bus      (bus),
        .ERR_IRQ  (ERR_IRQ),
        .ERR_CLR  (ERR_CLR),
        .ERR_COUNT(ERR_COUNT),
        .ERR_ADDR (ERR_ADDR),
        .ERR_WRITE(ERR_WRITE)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic drv();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        ERR_CLR = 1'b0;
        bus.HADDR = 32'h4000_0000;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HREADYOUT_S = 4'b1111;
        bus.HRESP_S = 4'b0000;
        bus.HRDATA_S = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        repeat (3) drv();
        smp();
        n_cmp++; if (bus.HREADY !== 1'b1) begin n_bad++; $display("FAIL rst_hready got %b want 1", bus.HREADY); end
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL rst_hresp got %b want 0", bus.HRESP); end
        n_cmp++; if (bus.HRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata got %h want 0", bus.HRDATA); end
        n_cmp++; if (bus.HSEL_S !== 4'b0000) begin n_bad++; $display("FAIL rst_hsel got %b want 0000", bus.HSEL_S); end
        n_cmp++; if (ERR_IRQ !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", ERR_IRQ); end
        n_cmp++; if (ERR_COUNT !== 16'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", ERR_COUNT); end
        n_cmp++; if (ERR_ADDR !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", ERR_ADDR); end
        n_cmp++; if (ERR_WRITE !== 1'b0) begin n_bad++; $display("FAIL rst_write got %b want 0", ERR_WRITE); end
        drv();
        HRESETn = 1'b1;
    endtask

    task automatic test_read();
        drv();
        bus.HADDR = 32'h1FC0_0010; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
        smp();
        n_cmp++; if (bus.HSEL_S !== 4'b0001) begin n_bad++; $display("FAIL rd_hsel got %b want 0001", bus.HSEL_S); end
        drv();
        bus.HTRANS = 2'b00;
        smp();
        n_cmp++; if (bus.HRDATA !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data got %h want deadbeef", bus.HRDATA); end
        n_cmp++; if (bus.HREADY !== 1'b1) begin n_bad++; $display("FAIL rd_hready got %b want 1", bus.HREADY); end
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL rd_hresp got %b want 0", bus.HRESP); end
    endtask

    task automatic test_wait_states();
        drv();
        bus.HADDR = 32'h0001_0000; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
        smp();
        n_cmp++; if (bus.HSEL_S !== 4'b0010) begin n_bad++; $display("FAIL ws_hsel got %b want 0010", bus.HSEL_S); end
        for (int k = 0; k < 3; k++) begin
            drv();
            bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
            bus.HREADYOUT_S = 4'b1101;
            smp();
            n_cmp++; if (bus.HREADY !== 1'b0) begin n_bad++; $display("FAIL ws_low%0d got %b want 0", k, bus.HREADY); end
        end
        drv();
        bus.HREADYOUT_S = 4'b1111;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b1) begin n_bad++; $display("FAIL ws_done got %b want 1", bus.HREADY); end
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL ws_hresp got %b want 0", bus.HRESP); end
        n_cmp++; if (ERR_COUNT !== 16'd0) begin n_bad++; $display("FAIL ws_count got %0d want 0", ERR_COUNT); end
    endtask

    task automatic test_unmapped();
        drv();
        bus.HADDR = 32'h4000_0000; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
        smp();
        n_cmp++; if (bus.HSEL_S !== 4'b0000) begin n_bad++; $display("FAIL um_hsel got %b want 0000", bus.HSEL_S); end
        drv();
        // presented during ERR1: must not be accepted
        bus.HADDR = 32'h5000_0000; bus.HTRANS = 2'b10;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b0) begin n_bad++; $display("FAIL um_e1_hready got %b want 0", bus.HREADY); end
        n_cmp++; if (bus.HRESP !== 1'b1) begin n_bad++; $display("FAIL um_e1_hresp got %b want 1", bus.HRESP); end
        n_cmp++; if (bus.HRDATA !== 32'h0) begin n_bad++; $display("FAIL um_e1_hrdata got %h want 0", bus.HRDATA); end
        n_cmp++; if (ERR_ADDR !== 32'h4000_0000) begin n_bad++; $display("FAIL um_addr got %h want 40000000", ERR_ADDR); end
        n_cmp++; if (ERR_COUNT !== 16'd1) begin n_bad++; $display("FAIL um_count got %0d want 1", ERR_COUNT); end
        n_cmp++; if (ERR_IRQ !== 1'b1) begin n_bad++; $display("FAIL um_irq got %b want 1", ERR_IRQ); end
        n_cmp++; if (ERR_WRITE !== 1'b0) begin n_bad++; $display("FAIL um_write got %b want 0", ERR_WRITE); end
        drv();
        bus.HTRANS = 2'b00;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b1) begin n_bad++; $display("FAIL um_e2_hready got %b want 1", bus.HREADY); end
        n_cmp++; if (bus.HRESP !== 1'b1) begin n_bad++; $display("FAIL um_e2_hresp got %b want 1", bus.HRESP); end
        drv();
        smp();
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL um_after_hresp got %b want 0", bus.HRESP); end
        n_cmp++; if (ERR_COUNT !== 16'd1) begin n_bad++; $display("FAIL um_after_count got %0d want 1", ERR_COUNT); end
        n_cmp++; if (ERR_ADDR !== 32'h4000_0000) begin n_bad++; $display("FAIL um_after_addr got %h want 40000000", ERR_ADDR); end
    endtask

    task automatic test_idle_busy_clr();
        drv();
        bus.HADDR = 32'h4000_0000; bus.HTRANS = 2'b00;
        drv();
        bus.HTRANS = 2'b01;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL ib_idle got rdy=%b resp=%b want 1/0", bus.HREADY, bus.HRESP); end
        drv();
        bus.HTRANS = 2'b00;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL ib_busy got rdy=%b resp=%b want 1/0", bus.HREADY, bus.HRESP); end
        n_cmp++; if (ERR_COUNT !== 16'd1) begin n_bad++; $display("FAIL ib_count got %0d want 1", ERR_COUNT); end
        drv();
        bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; ERR_CLR = 1'b1;
        drv();
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; ERR_CLR = 1'b0;
        smp();
        n_cmp++; if (ERR_IRQ !== 1'b1) begin n_bad++; $display("FAIL clr_set_irq got %b want 1", ERR_IRQ); end
        n_cmp++; if (ERR_COUNT !== 16'd2) begin n_bad++; $display("FAIL clr_set_count got %0d want 2", ERR_COUNT); end
        n_cmp++; if (ERR_WRITE !== 1'b1) begin n_bad++; $display("FAIL clr_set_write got %b want 1", ERR_WRITE); end
        drv();
        drv();
        ERR_CLR = 1'b1;
        drv();
        ERR_CLR = 1'b0;
        smp();
        n_cmp++; if (ERR_IRQ !== 1'b0) begin n_bad++; $display("FAIL clr_irq got %b want 0", ERR_IRQ); end
        n_cmp++; if (ERR_COUNT !== 16'd2) begin n_bad++; $display("FAIL clr_count got %0d want 2", ERR_COUNT); end
    endtask

    task automatic test_slave_error_overlap();
        drv();
        bus.HADDR = 32'h1F40_0100; bus.HTRANS = 2'b10;
        smp();
        n_cmp++; if (bus.HSEL_S !== 4'b0100) begin n_bad++; $display("FAIL se_hsel got %b want 0100", bus.HSEL_S); end
        drv();
        bus.HTRANS = 2'b00; bus.HREADYOUT_S = 4'b1011; bus.HRESP_S = 4'b0100;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b0 || bus.HRESP !== 1'b1) begin n_bad++; $display("FAIL se_c1 got rdy=%b resp=%b want 0/1", bus.HREADY, bus.HRESP); end
        drv();
        bus.HREADYOUT_S = 4'b1111;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b1) begin n_bad++; $display("FAIL se_c2 got rdy=%b resp=%b want 1/1", bus.HREADY, bus.HRESP); end
        drv();
        bus.HRESP_S = 4'b0000;
        smp();
        n_cmp++; if (bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL se_after got %b want 0", bus.HRESP); end
        n_cmp++; if (ERR_COUNT !== 16'd2) begin n_bad++; $display("FAIL se_count got %0d want 2", ERR_COUNT); end
        drv();
        bus.HADDR = 32'h1FC0_0010;
        #1;
        n_cmp++; if (bus.HSEL_S !== 4'b0001) begin n_bad++; $display("FAIL ov_win got %b want 0001", bus.HSEL_S); end
        bus.HADDR = 32'h1FD0_0000;
        #1;
        n_cmp++; if (bus.HSEL_S !== 4'b1000) begin n_bad++; $display("FAIL ov_s3 got %b want 1000", bus.HSEL_S); end
    endtask

    task automatic test_reset_in_err1();
        drv();
        bus.HADDR = 32'h6000_0000; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
        drv();
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        smp();
        n_cmp++; if (bus.HREADY !== 1'b0) begin n_bad++; $display("FAIL re_e1 got %b want 0", bus.HREADY); end
        n_cmp++; if (ERR_COUNT !== 16'd3) begin n_bad++; $display("FAIL re_count got %0d want 3", ERR_COUNT); end
        #1;
        HRESETn = 1'b0;
        #1;
        n_cmp++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin n_bad++; $display("FAIL re_bus got rdy=%b resp=%b data=%h want 1/0/0", bus.HREADY, bus.HRESP, bus.HRDATA); end
        n_cmp++; if (ERR_IRQ !== 1'b0 || ERR_COUNT !== 16'd0) begin n_bad++; $display("FAIL re_log got irq=%b cnt=%0d want 0/0", ERR_IRQ, ERR_COUNT); end
        n_cmp++; if (ERR_ADDR !== 32'h0 || ERR_WRITE !== 1'b0) begin n_bad++; $display("FAIL re_addr got %h/%b want 0/0", ERR_ADDR, ERR_WRITE); end
        drv();
        drv();
        HRESETn = 1'b1;
        drv();
        bus.HADDR = 32'h1F80_0004; bus.HTRANS = 2'b10;
        smp();
        n_cmp++; if (bus.HSEL_S !== 4'b1000) begin n_bad++; $display("FAIL re_hsel got %b want 1000", bus.HSEL_S); end
        drv();
        bus.HTRANS = 2'b00; bus.HRDATA_S[127:96] = 32'hCAFE_0004;
        smp();
        n_cmp++; if (bus.HRDATA !== 32'hCAFE_0004) begin n_bad++; $display("FAIL re_data got %h want cafe0004", bus.HRDATA); end
        n_cmp++; if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin n_bad++; $display("FAIL re_okay got rdy=%b resp=%b want 1/0", bus.HREADY, bus.HRESP); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_read();
        test_wait_states();
        test_unmapped();
        test_idle_busy_clr();
        test_slave_error_overlap();
        test_reset_in_err1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
